ps2_ascii_decoder: RTL and testbench

- Sequential successor to the combinational scan-code-to-LCD mapper.
- Consumes PS/2 Set-2 bytes from the keyboard receiver and tracks make/break (F0) and extended (E0) prefixes.
- Maintains Shift and Caps Lock state and produces case-correct ASCII or LCD command bytes.
- Output bytes are buffered in a parameterised first-word-fall-through (FWFT) FIFO with a valid/ready handshake, feeding the LCD write controller.

---
 rtl/ps2_ascii_decoder.sv | 179 +++++++++++++++++
 tb/tb_ps2_ascii_decoder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ps2_ascii_decoder.sv
// rtl/ps2_ascii_decoder.sv - PS/2 Set-2 scan bytes to case-correct ASCII/LCD bytes, buffered in an FWFT FIFO
module ps2_ascii_decoder #(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] ENTER_CODE = 8'hC0,
  parameter logic [7:0] BS_CODE    = 8'h10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    code_in,
  input  logic                          code_valid,
  output logic [7:0]                    ascii_out,
  output logic                          rs_out,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          caps_led,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BREAK, S_EXT_BREAK} state_t;

  // Returns {hit, rs, data} for a make code given the current modifier state.
  function automatic logic [9:0] map_code(input logic [7:0] code, input logic shift,
                                          input logic caps);
    logic [9:0] r;
    logic [4:0] li;
    logic [3:0] di;
    logic [7:0] sd;
    r  = '0;
    li = 5'd31;
    di = 4'hF;
    sd = 8'h00;
    case (code)
      8'h1C: li = 5'd0;   8'h32: li = 5'd1;   8'h21: li = 5'd2;   8'h23: li = 5'd3;
      8'h24: li = 5'd4;   8'h2B: li = 5'd5;   8'h34: li = 5'd6;   8'h33: li = 5'd7;
      8'h43: li = 5'd8;   8'h3B: li = 5'd9;   8'h42: li = 5'd10;  8'h4B: li = 5'd11;
      8'h3A: li = 5'd12;  8'h31: li = 5'd13;  8'h44: li = 5'd14;  8'h4D: li = 5'd15;
      8'h15: li = 5'd16;  8'h2D: li = 5'd17;  8'h1B: li = 5'd18;  8'h2C: li = 5'd19;
      8'h3C: li = 5'd20;  8'h2A: li = 5'd21;  8'h1D: li = 5'd22;  8'h22: li = 5'd23;
      8'h35: li = 5'd24;  8'h1A: li = 5'd25;
      default: li = 5'd31;
    endcase
    case (code)
      8'h45: di = 4'd0;  8'h16: di = 4'd1;  8'h1E: di = 4'd2;  8'h26: di = 4'd3;
      8'h25: di = 4'd4;  8'h2E: di = 4'd5;  8'h36: di = 4'd6;  8'h3D: di = 4'd7;
      8'h3E: di = 4'd8;  8'h46: di = 4'd9;
      default: di = 4'hF;
    endcase
    case (di)
      4'd0: sd = 8'h29;  4'd1: sd = 8'h21;  4'd2: sd = 8'h40;  4'd3: sd = 8'h23;
      4'd4: sd = 8'h24;  4'd5: sd = 8'h25;  4'd6: sd = 8'h5E;  4'd7: sd = 8'h26;
      4'd8: sd = 8'h2A;  4'd9: sd = 8'h28;
      default: sd = 8'h00;
    endcase
    if (li != 5'd31) begin
      r = {2'b11, ((shift ^ caps) ? 8'h41 : 8'h61) + {3'b000, li}};
    end else if (di != 4'hF) begin
      r = {2'b11, shift ? sd : (8'h30 + {4'h0, di})};
    end else if (code == 8'h29) begin
      r = {2'b11, 8'h20};
    end else if (code == 8'h5A) begin
      r = {2'b10, ENTER_CODE};
    end else if (code == 8'h66) begin
      r = {2'b10, BS_CODE};
    end
    return r;
  endfunction

  state_t          state_q, state_d;
  logic            shift_l_q, shift_l_d, shift_r_q, shift_r_d;
  logic            caps_q, caps_d, caps_held_q, caps_held_d;
  logic [8:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [8:0]      last_q, last_d;
  logic            overflow_q, overflow_d;
  logic            is_make, is_release, push_req, push, pop, full;
  logic [9:0]      mapped;
  logic [8:0]      head;

  assign is_make    = code_valid && (state_q == S_IDLE) && (code_in != 8'hE0) && (code_in != 8'hF0);
  assign is_release = code_valid && (state_q == S_BREAK);
  assign mapped     = map_code(code_in, shift_l_q | shift_r_q, caps_q);
  assign push_req   = is_make && mapped[9];
  assign full       = (count_q == CW'(FIFO_DEPTH));
  assign pop        = (count_q != '0) && out_ready;
  assign push       = push_req && (!full || pop);

  always_comb begin
    state_d     = state_q;
    shift_l_d   = shift_l_q;
    shift_r_d   = shift_r_q;
    caps_d      = caps_q;
    caps_held_d = caps_held_q;
    if (code_valid) begin
      case (state_q)
        S_IDLE:  state_d = (code_in == 8'hE0) ? S_EXT : (code_in == 8'hF0) ? S_BREAK : S_IDLE;
        S_EXT:   state_d = (code_in == 8'hF0) ? S_EXT_BREAK : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    if (is_make) begin
      case (code_in)
        8'h12: shift_l_d = 1'b1;
        8'h59: shift_r_d = 1'b1;
        8'h58: begin
          // Typematic repeats of Caps Lock arrive with caps_held set and must not re-toggle.
          if (!caps_held_q) caps_d = ~caps_q;
          caps_held_d = 1'b1;
        end
        default: ;
      endcase
    end
    if (is_release) begin
      case (code_in)
        8'h12:   shift_l_d   = 1'b0;
        8'h59:   shift_r_d   = 1'b0;
        8'h58:   caps_held_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    last_d     = pop ? mem_q[rd_ptr_q] : last_q;
    overflow_d = push_req && full && !pop;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shift_l_q   <= 1'b0;
      shift_r_q   <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      last_q      <= 9'h100;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_l_q   <= shift_l_d;
      shift_r_q   <= shift_r_d;
      caps_q      <= caps_d;
      caps_held_q <= caps_held_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      last_q      <= last_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= mapped[8:0];
  end

  // When empty the outputs keep showing the last popped entry rather than stale storage.
  assign head       = (count_q != '0) ? mem_q[rd_ptr_q] : last_q;
  assign rs_out     = head[8];
  assign ascii_out  = head[7:0];
  assign out_valid  = (count_q != '0);
  assign caps_led   = caps_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
// tb/tb_ps2_ascii_decoder.sv - table-driven and directed checks for ps2_ascii_decoder
module tb_ps2_ascii_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] code_in;
  logic       code_valid;
  logic [7:0] ascii_out;
  logic       rs_out;
  logic       out_valid;
  logic       out_ready;
  logic       caps_led;
  logic [3:0] fifo_count;
  logic       overflow;

  int n_checks = 0;
  int n_errors = 0;
  int ovf_seen;

  typedef struct {
    logic [7:0] code;
    logic       exp_valid;
    logic       exp_rs;
    logic [7:0] exp_data;
    logic       exp_caps;
  } vec_t;

  vec_t vecs[$];

  ps2_ascii_decoder #(.FIFO_DEPTH(8), .ENTER_CODE(8'hC0), .BS_CODE(8'h10)) dut (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid),
    .ascii_out(ascii_out), .rs_out(rs_out), .out_valid(out_valid), .out_ready(out_ready),
    .caps_led(caps_led), .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] c, input logic v, input logic r,
                     input logic [7:0] d, input logic cp);
    vec_t e;
    e.code = c; e.exp_valid = v; e.exp_rs = r; e.exp_data = d; e.exp_caps = cp;
    vecs.push_back(e);
  endtask

  initial begin
    rst = 1'b1; code_in = 8'h00; code_valid = 1'b0; out_ready = 1'b0;

    // no-push entries: (code, 0, 1, 00, caps)
    add(8'h12,0,1,8'h00,0); add(8'h1C,1,1,8'h41,0); add(8'hF0,0,1,8'h00,0); add(8'h1C,0,1,8'h00,0);
    add(8'hF0,0,1,8'h00,0); add(8'h12,0,1,8'h00,0); add(8'h1C,1,1,8'h61,0);
    add(8'h58,0,1,8'h00,1); add(8'h58,0,1,8'h00,1); add(8'hF0,0,1,8'h00,1); add(8'h58,0,1,8'h00,1);
    add(8'h32,1,1,8'h42,1); add(8'h12,0,1,8'h00,1); add(8'h32,1,1,8'h62,1);
    add(8'hF0,0,1,8'h00,1); add(8'h12,0,1,8'h00,1); add(8'h16,1,1,8'h31,1);
    add(8'h58,0,1,8'h00,0); add(8'hF0,0,1,8'h00,0); add(8'h58,0,1,8'h00,0);
    add(8'h12,0,1,8'h00,0); add(8'h1E,1,1,8'h40,0); add(8'hF0,0,1,8'h00,0); add(8'h12,0,1,8'h00,0);
    add(8'h5A,1,0,8'hC0,0); add(8'h66,1,0,8'h10,0);
    add(8'hE0,0,1,8'h00,0); add(8'h75,0,1,8'h00,0); add(8'hE0,0,1,8'h00,0); add(8'hF0,0,1,8'h00,0);
    add(8'h75,0,1,8'h00,0); add(8'hF0,0,1,8'h00,0); add(8'hE0,0,1,8'h00,0); add(8'h29,1,1,8'h20,0);
    add(8'h76,0,1,8'h00,0); add(8'h45,1,1,8'h30,0);
    add(8'h59,0,1,8'h00,0); add(8'h46,1,1,8'h28,0); add(8'h1A,1,1,8'h5A,0);
    add(8'hF0,0,1,8'h00,0); add(8'h59,0,1,8'h00,0); add(8'h1A,1,1,8'h7A,0);

    // Reset state
    @(negedge clk); @(negedge clk);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset ascii_out", 32'(ascii_out), 32'h00);
    check("reset rs_out", 32'(rs_out), 32'd1);
    check("reset caps_led", 32'(caps_led), 32'd0);
    check("reset fifo_count", 32'(fifo_count), 32'd0);
    check("reset overflow", 32'(overflow), 32'd0);
    rst = 1'b0;

    // Single make, latency 1, then pop
    @(negedge clk); code_in = 8'h1C; code_valid = 1'b1;
    @(negedge clk); code_valid = 1'b0;
    check("first out_valid", 32'(out_valid), 32'd1);
    check("first ascii_out", 32'(ascii_out), 32'h61);
    check("first rs_out", 32'(rs_out), 32'd1);
    check("first fifo_count", 32'(fifo_count), 32'd1);
    out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    check("after pop out_valid", 32'(out_valid), 32'd0);
    check("after pop fifo_count", 32'(fifo_count), 32'd0);
    check("after pop holds last", 32'(ascii_out), 32'h61);

    // Table: each byte sent, sampled one cycle later, then popped by out_ready=1
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      @(negedge clk); code_in = vecs[i].code; code_valid = 1'b1;
      @(negedge clk); code_valid = 1'b0;
      check($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d ascii_out", i), 32'(ascii_out), 32'(vecs[i].exp_data));
        check($sformatf("vec%0d rs_out", i), 32'(rs_out), 32'(vecs[i].exp_rs));
      end
      check($sformatf("vec%0d caps_led", i), 32'(caps_led), 32'(vecs[i].exp_caps));
    end
    @(negedge clk);
    check("table drained", 32'(fifo_count), 32'd0);

    // Fill past full with no consumer
    out_ready = 1'b0;
    ovf_seen = 0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk); ovf_seen += int'(overflow); code_in = 8'h1C; code_valid = 1'b1;
    end
    @(negedge clk); ovf_seen += int'(overflow); code_valid = 1'b0;
    check("full fifo_count", 32'(fifo_count), 32'd8);
    check("overflow pulses", 32'(ovf_seen), 32'd1);

    // Push with simultaneous pop while full
    code_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk); code_valid = 1'b0; out_ready = 1'b0;
    check("push+pop full count", 32'(fifo_count), 32'd8);
    check("push+pop no overflow", 32'(overflow), 32'd0);

    // Drain all eight entries
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("drain%0d out_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("drain%0d ascii_out", k), 32'(ascii_out), 32'h61);
      @(negedge clk);
    end
    check("drained out_valid", 32'(out_valid), 32'd0);
    check("drained fifo_count", 32'(fifo_count), 32'd0);
    check("drained holds last", 32'(ascii_out), 32'h61);
    check("ready while empty", 32'(overflow), 32'd0);

    // Reset mid-drain
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); code_in = 8'h32; code_valid = 1'b1;
    end
    @(negedge clk); code_valid = 1'b0; out_ready = 1'b1;
    check("pre-reset count", 32'(fifo_count), 32'd3);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; out_ready = 1'b0;
    check("mid-drain reset out_valid", 32'(out_valid), 32'd0);
    check("mid-drain reset count", 32'(fifo_count), 32'd0);
    check("mid-drain reset ascii_out", 32'(ascii_out), 32'h00);
    check("mid-drain reset rs_out", 32'(rs_out), 32'd1);

    // Reset after Caps make and a pending F0 discards both
    @(negedge clk); code_in = 8'h58; code_valid = 1'b1;
    @(negedge clk); code_in = 8'hF0;
    @(negedge clk); code_valid = 1'b0;
    check("caps before reset", 32'(caps_led), 32'd1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("caps cleared by reset", 32'(caps_led), 32'd0);
    @(negedge clk); code_in = 8'h1C; code_valid = 1'b1;
    @(negedge clk); code_valid = 1'b0;
    check("post-reset make out_valid", 32'(out_valid), 32'd1);
    check("post-reset make ascii_out", 32'(ascii_out), 32'h61);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
